// File: rtl/aes_round_sequencer_if.sv
// ---------------------------------------------------------------------------
// aes_round_sequencer_if
//
// Bundles every non-clock signal of the iterative AES round sequencer:
//   start_valid/start_ready/plaintext : block input handshake
//   rk_idx/round_key                  : round-key lookup into the key store
//   rnd_state/rnd_final/rnd_result    : loop through the external round unit
//   out_valid/out_ready/ciphertext    : result handshake
//   busy                              : controller is not idle
//
// slave  : view used by the sequencer itself
// master : view used by whatever surrounds it (system, key store, round unit)
// ---------------------------------------------------------------------------
interface aes_round_sequencer_if;
  logic         start_valid;
  logic         start_ready;
  logic [127:0] plaintext;
  logic [3:0]   rk_idx;
  logic [127:0] round_key;
  logic [127:0] rnd_state;
  logic         rnd_final;
  logic [127:0] rnd_result;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;

  modport slave (
    input  start_valid, plaintext, round_key, rnd_result, out_ready,
    output start_ready, rk_idx, rnd_state, rnd_final, out_valid, ciphertext, busy
  );

  modport master (
    output start_valid, plaintext, round_key, rnd_result, out_ready,
    input  start_ready, rk_idx, rnd_state, rnd_final, out_valid, ciphertext, busy
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// aes_round_sequencer
//
// Iterative AES encryption controller. Holds the 128-bit cipher state and
// walks one external single-round unit over NR rounds, applying AddRoundKey
// itself with keys fetched by index from an external key-expansion store.
//
// Ports:
//   clk    : single clock, rising edge
//   reset  : asynchronous, active-high; aborts any block in flight
//   bus    : aes_round_sequencer_if.slave
//            start_valid/start_ready/plaintext  - accept a block
//            rk_idx -> round_key                - combinational key lookup
//            rnd_state/rnd_final -> rnd_result  - combinational round unit
//            out_valid/out_ready/ciphertext     - deliver the result
//            busy                               - FSM is not IDLE
//
// Parameters:
//   NK : key length in 32-bit words (4/6/8), only checked against NR
//   NR : number of cipher rounds (10/12/14)
// ---------------------------------------------------------------------------
module aes_round_sequencer #(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input logic                   clk,
  input logic                   reset,
  aes_round_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } FsmState;

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  FsmState      r_fsm;
  FsmState      w_fsmNext;
  logic [127:0] r_blockState;
  logic [127:0] r_ciphertext;
  logic [3:0]   r_roundCnt;
  logic [127:0] w_roundOut;
  logic [3:0]   w_rkIdx;
  logic         w_startReady;
  logic         w_outValid;
  logic         w_rndFinal;
  logic         w_loadInit;
  logic         w_loadRound;
  logic         w_lastRound;

  // AES only defines NR = NK + 6; any other pairing is a wiring mistake.
  generate
    if (NR != NK + 6) begin : g_paramCheck
      $error("aes_round_sequencer: NR (%0d) must equal NK + 6 (NK = %0d)", NR, NK);
    end
  endgenerate

  assign w_lastRound = (r_roundCnt == LAST_ROUND);

  // AddRoundKey on top of the external round unit's result.
  assign w_roundOut = bus.rnd_result ^ bus.round_key;

  // State register for the controller; reset drops straight back to IDLE so
  // out_valid and busy fall without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fsm <= IDLE;
    end else begin
      r_fsm <= w_fsmNext;
    end
  end

  // Next-state and control decode. IDLE presents key 0 so the initial
  // AddRoundKey can be done on the accept edge; ROUND presents the key for
  // the current round and flags the last one so MixColumns is skipped.
  always_comb begin
    w_fsmNext    = r_fsm;
    w_startReady = 1'b0;
    w_outValid   = 1'b0;
    w_rkIdx      = 4'd0;
    w_rndFinal   = 1'b0;
    w_loadInit   = 1'b0;
    w_loadRound  = 1'b0;
    case (r_fsm)
      IDLE: begin
        w_startReady = 1'b1;
        if (bus.start_valid) begin
          w_loadInit = 1'b1;
          w_fsmNext  = ROUND;
        end
      end
      ROUND: begin
        w_rkIdx     = r_roundCnt;
        w_rndFinal  = w_lastRound;
        w_loadRound = 1'b1;
        if (w_lastRound) begin
          w_fsmNext = DONE;
        end
      end
      DONE: begin
        w_outValid = 1'b1;
        if (bus.out_ready) begin
          w_fsmNext = IDLE;
        end
      end
      default: begin
        w_fsmNext = IDLE;
      end
    endcase
  end

  // Cipher state, round counter and result holding register. The result is
  // captured separately on the final round so it survives the handshake and
  // stays put until the next block completes, even while the working state
  // is being overwritten by a later block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blockState <= '0;
      r_roundCnt   <= 4'd0;
      r_ciphertext <= '0;
    end else if (w_loadInit) begin
      r_blockState <= bus.plaintext ^ bus.round_key;
      r_roundCnt   <= 4'd1;
    end else if (w_loadRound) begin
      r_blockState <= w_roundOut;
      if (w_lastRound) begin
        r_ciphertext <= w_roundOut;
      end else begin
        r_roundCnt <= r_roundCnt + 4'd1;
      end
    end
  end

  // start_ready is held low while reset is asserted so nothing is offered
  // as acceptable before the controller is actually running.
  assign bus.start_ready = w_startReady & ~reset;
  assign bus.out_valid   = w_outValid;
  assign bus.rk_idx      = w_rkIdx;
  assign bus.rnd_final   = w_rndFinal;
  assign bus.rnd_state   = r_blockState;
  assign bus.ciphertext  = r_ciphertext;
  assign bus.busy        = (r_fsm != IDLE);

endmodule

// File: tb/tb_aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aes_round_sequencer
//
// Drives an AES-128 sequencer (index 0) and an AES-256 sequencer (index 1).
// The bench supplies a behavioural AES round unit and key schedule, or a stub
// pair (identity round, key = index). A timeline model follows each accepted
// block by counting edges since acceptance and predicts every output on each
// falling edge; directed literals pin the model against FIPS-197 vectors.
// ---------------------------------------------------------------------------
module tb_aes_round_sequencer;

  logic clk;
  logic reset;
  logic stubMode;

  logic         startValid [2];
  logic [127:0] plaintext  [2];
  logic         outReady   [2];
  logic         startReadyO[2];
  logic         busyO      [2];
  logic         outValidO  [2];
  logic         rndFinalO  [2];
  logic [3:0]   rkIdxO     [2];
  logic [127:0] rndStateO  [2];
  logic [127:0] ctO        [2];

  logic [127:0] rk [2][16];

  int compared   = 0;
  int mismatched = 0;

  // Timeline model state
  bit           inFlight[2];
  int           age     [2];
  logic [127:0] mState  [2];
  logic [127:0] lastCt  [2];

  aes_round_sequencer_if ifA();
  aes_round_sequencer_if ifB();

  aes_round_sequencer #(.NK(4), .NR(10)) dutA (.clk(clk), .reset(reset), .bus(ifA));
  aes_round_sequencer #(.NK(8), .NR(14)) dutB (.clk(clk), .reset(reset), .bus(ifB));

  always #5 clk = ~clk;

  // ---------------- AES behavioural helpers ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from first principles: inverse as x^254, then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    logic [7:0] p = x;
    for (int k = 1; k < 8; k++) begin
      p   = gmul(p, p);
      inv = gmul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aesRound(input logic [127:0] s, input logic final_);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) b[rr + 4*c] = a[rr + 4*((c + rr) % 4)];
    if (!final_) begin
      for (int c = 0; c < 4; c++) begin
        logic [7:0] a0, a1, a2, a3;
        a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
        b[4*c]   = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
        b[4*c+1] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
        b[4*c+2] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
        b[4*c+3] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
    return r;
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  task automatic expandKey(input int d, input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    int nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subWord(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk[d][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  function automatic int nrOf(input int d);
    return (d == 0) ? 10 : 14;
  endfunction

  function automatic logic [127:0] modelKey(input int d, input int i);
    return stubMode ? 128'(i) : rk[d][i];
  endfunction

  function automatic logic [127:0] modelEncrypt(input int d, input logic [127:0] pt);
    logic [127:0] s = pt ^ rk[d][0];
    for (int r = 1; r <= nrOf(d); r++) s = aesRound(s, r == nrOf(d)) ^ rk[d][r];
    return s;
  endfunction

  // ---------------- Wiring to the interfaces ----------------
  assign ifA.start_valid = startValid[0];
  assign ifA.plaintext   = plaintext[0];
  assign ifA.out_ready   = outReady[0];
  assign ifA.round_key   = stubMode ? {124'd0, ifA.rk_idx} : rk[0][ifA.rk_idx];
  assign ifA.rnd_result  = stubMode ? ifA.rnd_state : aesRound(ifA.rnd_state, ifA.rnd_final);
  assign ifB.start_valid = startValid[1];
  assign ifB.plaintext   = plaintext[1];
  assign ifB.out_ready   = outReady[1];
  assign ifB.round_key   = stubMode ? {124'd0, ifB.rk_idx} : rk[1][ifB.rk_idx];
  assign ifB.rnd_result  = stubMode ? ifB.rnd_state : aesRound(ifB.rnd_state, ifB.rnd_final);

  assign startReadyO[0] = ifA.start_ready;  assign startReadyO[1] = ifB.start_ready;
  assign busyO[0]       = ifA.busy;         assign busyO[1]       = ifB.busy;
  assign outValidO[0]   = ifA.out_valid;    assign outValidO[1]   = ifB.out_valid;
  assign rndFinalO[0]   = ifA.rnd_final;    assign rndFinalO[1]   = ifB.rnd_final;
  assign rkIdxO[0]      = ifA.rk_idx;       assign rkIdxO[1]      = ifB.rk_idx;
  assign rndStateO[0]   = ifA.rnd_state;    assign rndStateO[1]   = ifB.rnd_state;
  assign ctO[0]         = ifA.ciphertext;   assign ctO[1]         = ifB.ciphertext;

  // ---------------- Checking ----------------
  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic string nm(input string base, input int d);
    return $sformatf("%s[%0d]", base, d);
  endfunction

  // Timeline model: a block accepted at some edge is in round k+1 during the
  // k-th cycle after acceptance, shows its result from NR edges on, and
  // leaves on the first edge where out_ready is seen after that.
  initial begin
    forever begin
      @(posedge clk or posedge reset);
      for (int d = 0; d < 2; d++) begin
        if (reset) begin
          inFlight[d] = 0;
          age[d]      = 0;
          lastCt[d]   = '0;
        end else if (!inFlight[d]) begin
          if (startValid[d]) begin
            inFlight[d] = 1;
            age[d]      = 0;
            mState[d]   = plaintext[d] ^ modelKey(d, 0);
          end
        end else if (age[d] >= nrOf(d)) begin
          if (outReady[d]) inFlight[d] = 0;
        end else begin
          age[d]++;
          mState[d] = (stubMode ? mState[d] : aesRound(mState[d], age[d] == nrOf(d)))
                      ^ modelKey(d, age[d]);
          if (age[d] == nrOf(d)) lastCt[d] = mState[d];
        end
      end
    end
  end

  // Compare every output of both sequencers against the model each cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        checkOutput(nm("rstOutValid", d), 128'(outValidO[d]), 128'd0);
        checkOutput(nm("rstBusy", d),     128'(busyO[d]),     128'd0);
        checkOutput(nm("rstRkIdx", d),    128'(rkIdxO[d]),    128'd0);
        checkOutput(nm("rstCt", d),       ctO[d],             128'd0);
      end else if (!inFlight[d]) begin
        checkOutput(nm("idleReady", d),    128'(startReadyO[d]), 128'd1);
        checkOutput(nm("idleBusy", d),     128'(busyO[d]),       128'd0);
        checkOutput(nm("idleOutValid", d), 128'(outValidO[d]),   128'd0);
        checkOutput(nm("idleRkIdx", d),    128'(rkIdxO[d]),      128'd0);
        checkOutput(nm("idleFinal", d),    128'(rndFinalO[d]),   128'd0);
        checkOutput(nm("idleCt", d),       ctO[d],               lastCt[d]);
      end else if (age[d] < nrOf(d)) begin
        checkOutput(nm("rndReady", d),    128'(startReadyO[d]), 128'd0);
        checkOutput(nm("rndBusy", d),     128'(busyO[d]),       128'd1);
        checkOutput(nm("rndOutValid", d), 128'(outValidO[d]),   128'd0);
        checkOutput(nm("rndRkIdx", d),    128'(rkIdxO[d]),      128'(age[d] + 1));
        checkOutput(nm("rndFinal", d),    128'(rndFinalO[d]),   128'(age[d] + 1 == nrOf(d)));
        checkOutput(nm("rndState", d),    rndStateO[d],         mState[d]);
        checkOutput(nm("rndCt", d),       ctO[d],               lastCt[d]);
      end else begin
        checkOutput(nm("doneReady", d),    128'(startReadyO[d]), 128'd0);
        checkOutput(nm("doneBusy", d),     128'(busyO[d]),       128'd1);
        checkOutput(nm("doneOutValid", d), 128'(outValidO[d]),   128'd1);
        checkOutput(nm("doneRkIdx", d),    128'(rkIdxO[d]),      128'd0);
        checkOutput(nm("doneFinal", d),    128'(rndFinalO[d]),   128'd0);
        checkOutput(nm("doneCt", d),       ctO[d],               mState[d]);
      end
    end
  end

  // ---------------- Stimulus ----------------
  // Offers one block to sequencer d and returns the number of edges from the
  // accept edge until out_valid is seen. Called just after a rising edge.
  task automatic applyStimulus(input int d, input logic [127:0] pt, output int lat);
    checkOutput(nm("readyBeforeAccept", d), 128'(startReadyO[d]), 128'd1);
    startValid[d] = 1'b1;
    plaintext[d]  = pt;
    @(posedge clk); #1;
    startValid[d] = 1'b0;
    plaintext[d]  = {$urandom, $urandom, $urandom, $urandom};
    lat = 0;
    while (!outValidO[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!outValidO[d]) checkOutput(nm("outValidTimeout", d), 128'd0, 128'd1);
  endtask

  task automatic waitIdle(input int d);
    int n = 0;
    while (busyO[d] && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (busyO[d]) checkOutput(nm("idleTimeout", d), 128'd1, 128'd0);
  endtask

  localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C2_PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2_CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    int lat;
    int n;
    clk      = 1'b0;
    reset    = 1'b1;
    stubMode = 1'b1;
    for (int d = 0; d < 2; d++) begin
      startValid[d] = 1'b0;
      plaintext[d]  = '0;
      outReady[d]   = 1'b1;
    end
    expandKey(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
    expandKey(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);

    // Pin the bench's own AES model to known values.
    checkOutput("pinSbox00", 128'(sbox(8'h00)), 128'h63);
    checkOutput("pinSbox53", 128'(sbox(8'h53)), 128'hed);
    checkOutput("pinModel128", modelEncrypt(0, FIPS_PT), FIPS_CT);
    checkOutput("pinModel256", modelEncrypt(1, C2_PT), C2_CT256);

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1 checkOutput("readyAfterReset", 128'(startReadyO[0]), 128'd1);
    @(posedge clk); #1;

    // Stub units: identity round, key = index -> XOR of 0..10 = 0x0B.
    applyStimulus(0, 128'h0, lat);
    checkOutput("stubLatency", 128'(lat), 128'd10);
    checkOutput("stubCt", ctO[0], 128'h0B);
    @(posedge clk); #1;
    waitIdle(0);

    // FIPS-197 AES-128 with the behavioural round and key units.
    stubMode = 1'b0;
    applyStimulus(0, FIPS_PT, lat);
    checkOutput("fips128Latency", 128'(lat), 128'd10);
    checkOutput("fips128Ct", ctO[0], FIPS_CT);
    @(posedge clk); #1;
    waitIdle(0);

    // Backpressure: result held while start_valid is pulsed, then a
    // handshake that coincides with start_valid does not accept.
    outReady[0] = 1'b0;
    applyStimulus(0, {$urandom, $urandom, $urandom, $urandom}, lat);
    for (int i = 0; i < 5; i++) begin
      startValid[0] = (i % 2 == 0);
      plaintext[0]  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      checkOutput("bpReady", 128'(startReadyO[0]), 128'd0);
      checkOutput("bpOutValid", 128'(outValidO[0]), 128'd1);
      @(posedge clk); #1;
    end
    outReady[0]   = 1'b1;
    startValid[0] = 1'b1;
    @(posedge clk); #1;
    checkOutput("bpReleaseBusy", 128'(busyO[0]), 128'd0);
    checkOutput("bpReleaseReady", 128'(startReadyO[0]), 128'd1);
    @(posedge clk); #1;
    checkOutput("bpNextAccepted", 128'(busyO[0]), 128'd1);
    startValid[0] = 1'b0;
    waitIdle(0);

    // Reset mid-run while round key 5 is being requested.
    startValid[0] = 1'b1;
    plaintext[0]  = FIPS_PT;
    @(posedge clk); #1;
    startValid[0] = 1'b0;
    n = 0;
    while (rkIdxO[0] != 4'd5 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midRunRkIdx", 128'(rkIdxO[0]), 128'd5);
    #2 reset = 1'b1;
    #1;
    checkOutput("asyncOutValid", 128'(outValidO[0]), 128'd0);
    checkOutput("asyncBusy", 128'(busyO[0]), 128'd0);
    checkOutput("asyncRkIdx", 128'(rkIdxO[0]), 128'd0);
    checkOutput("asyncFinal", 128'(rndFinalO[0]), 128'd0);
    checkOutput("asyncCt", ctO[0], 128'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1 checkOutput("readyAfterMidReset", 128'(startReadyO[0]), 128'd1);
    @(posedge clk); #1;
    applyStimulus(0, FIPS_PT, lat);
    checkOutput("postResetLatency", 128'(lat), 128'd10);
    checkOutput("postResetCt", ctO[0], FIPS_CT);
    @(posedge clk); #1;
    waitIdle(0);

    // Randomised traffic on both sequencers against the model.
    for (int c = 0; c < 300; c++) begin
      for (int d = 0; d < 2; d++) begin
        startValid[d] = ($urandom_range(0, 1) == 1);
        plaintext[d]  = {$urandom, $urandom, $urandom, $urandom};
        outReady[d]   = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
    end
    for (int d = 0; d < 2; d++) begin
      startValid[d] = 1'b0;
      outReady[d]   = 1'b1;
    end
    waitIdle(0);
    waitIdle(1);

    // AES-256 vector on the NK=8 / NR=14 instance.
    applyStimulus(1, C2_PT, lat);
    checkOutput("aes256Latency", 128'(lat), 128'd14);
    checkOutput("aes256Ct", ctO[1], C2_CT256);
    @(posedge clk); #1;
    waitIdle(1);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, compared %0d mismatched %0d",
             compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
